// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - fetch-PC control/status bundle between next-PC logic and the PC unit
interface pc_unit_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            jump;
   logic [XLEN-1:0] jump_target;
   logic            trap;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_plus;
   logic            pc_valid;
   logic [XLEN-1:0] epc;
   logic            misaligned;

   // execute-side view: issues redirects, observes the fetch PC
   modport master (
      output stall, branch_taken, branch_target, jump, jump_target, trap,
      input  pc_out, pc_plus, pc_valid, epc, misaligned
   );

   // PC-unit view
   modport slave (
      input  stall, branch_taken, branch_target, jump, jump_target, trap,
      output pc_out, pc_plus, pc_valid, epc, misaligned
   );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - RV32I fetch PC unit with stall, pending redirect, bubble and EPC; option macro PC_ALIGN_CHECK_EN
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 'h0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
   parameter int              INC_BYTES    = 4,
   parameter int              BUBBLE_CYC   = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   pc_unit_if.slave     bus
);
   typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

   localparam logic [XLEN-1:0] INC      = XLEN'(INC_BYTES);
   localparam logic [1:0]      BUB_INIT = (BUBBLE_CYC == 0) ? 2'd0 : 2'(BUBBLE_CYC - 1);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] epc;
   logic            pc_valid;
   logic            misaligned;
   logic [1:0]      bub_cnt;
   logic            pend_valid;
   logic [XLEN-1:0] pend_target;

   logic            redirect_req;
   logic [XLEN-1:0] redirect_tgt;
   logic            apply;
   logic [XLEN-1:0] apply_tgt;
   logic [XLEN-1:0] load_tgt;
   logic            fault;

   assign bus.pc_out     = pc;
   assign bus.pc_plus    = pc + INC;
   assign bus.pc_valid   = pc_valid;
   assign bus.epc        = epc;
   assign bus.misaligned = misaligned;

   // Resolve which redirect (new one or buffered one) lands this cycle; jump outranks branch
   always_comb begin
      redirect_req = bus.jump | bus.branch_taken;
      redirect_tgt = bus.jump ? bus.jump_target : bus.branch_target;
      apply        = 1'b0;
      apply_tgt    = pend_target;
      if (!bus.stall) begin
         if (redirect_req) begin
            apply     = 1'b1;
            apply_tgt = redirect_tgt;
         end else if (pend_valid) begin
            apply     = 1'b1;
         end
      end
`ifdef PC_ALIGN_CHECK_EN
      load_tgt = apply_tgt;
      fault    = apply && (apply_tgt[1:0] != 2'b00);
`else
      load_tgt = apply_tgt & ~XLEN'(3);
      fault    = 1'b0;
`endif
   end

   // PC / EPC / pending buffer update and BOOT-RUN-BUBBLE sequencing with registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= BOOT;
         pc          <= RESET_VECTOR;
         epc         <= '0;
         pc_valid    <= 1'b0;
         misaligned  <= 1'b0;
         bub_cnt     <= 2'd0;
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else begin
         misaligned <= 1'b0;
         case (state)
            BOOT: begin
               // boot cycle presents RESET_VECTOR without advancing it
               state    <= RUN;
               pc_valid <= 1'b1;
            end
            default: begin
               if (bus.trap || fault) begin
                  pc         <= TRAP_VECTOR;
                  epc        <= pc;
                  pend_valid <= 1'b0;
                  misaligned <= fault;
                  if (BUBBLE_CYC == 0) begin
                     state    <= RUN;
                     pc_valid <= 1'b1;
                  end else begin
                     state    <= BUBBLE;
                     pc_valid <= 1'b0;
                     bub_cnt  <= BUB_INIT;
                  end
               end else if (apply) begin
                  pc         <= load_tgt;
                  pend_valid <= 1'b0;
                  if (BUBBLE_CYC == 0) begin
                     state    <= RUN;
                     pc_valid <= 1'b1;
                  end else begin
                     state    <= BUBBLE;
                     pc_valid <= 1'b0;
                     bub_cnt  <= BUB_INIT;
                  end
               end else begin
                  // a redirect seen under stall is parked; the newest one wins
                  if (redirect_req) begin
                     pend_valid  <= 1'b1;
                     pend_target <= redirect_tgt;
                  end
                  if (!bus.stall) begin
                     pc <= pc + INC;
                  end
                  // bubble length counts cycles, stalled or not
                  if (state == BUBBLE) begin
                     if (bub_cnt == 2'd0) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                     end else begin
                        bub_cnt <= bub_cnt - 2'd1;
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule
